// File: rtl/pc_fetch.sv
// Program counter and instruction-fetch stage: issues pc over a req/ready
// handshake, buffers words caught under a stall, and feeds the IF/ID register.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      next_pc,
  input  logic             stall,
  input  logic             flush,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_ready,
  output logic [31:0]      pc,
  output logic [31:0]      ifid_ir,
  output logic [31:0]      ifid_pc4,
  output logic             ifid_valid,
  output logic [CNT_W-1:0] fetch_wait_cnt
);

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [31:0]        pc_r;
  logic [31:0]        pc_nxt_s;
  logic [31:0]        ir_r;
  logic [31:0]        ir_nxt_s;
  logic [31:0]        pc4_r;
  logic [31:0]        pc4_nxt_s;
  logic               valid_r;
  logic               valid_nxt_s;
  logic [31:0]        buf_r;
  logic [31:0]        buf_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_nxt_s;
  logic [31:0]        pc_target_s;
  logic [31:0]        pc_plus4_s;
  logic               unused_low_bits_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Redirect target is always word aligned; the low bits of next_pc are dropped.
  assign pc_target_s       = {next_pc[31:2], 2'b00};
  assign unused_low_bits_s = ^next_pc[1:0];
  assign pc_plus4_s        = pc_r + 32'd4;

  // Request is a pure function of state, suppressed while reset is asserted.
  assign imem_req       = (state_r == ST_FETCH) && !reset;
  assign imem_addr      = pc_r;
  assign pc             = pc_r;
  assign ifid_ir        = ir_r;
  assign ifid_pc4       = pc4_r;
  assign ifid_valid     = valid_r;
  assign fetch_wait_cnt = cnt_r;

  // Next-state and datapath selection for both fetch states.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    ir_nxt_s    = ir_r;
    pc4_nxt_s   = pc4_r;
    valid_nxt_s = valid_r;
    buf_nxt_s   = buf_r;
    case (state_r)
      ST_FETCH: begin
        if (flush) begin
          pc_nxt_s    = pc_target_s;
          ir_nxt_s    = 32'h0000_0000;
          valid_nxt_s = 1'b0;
        end else if (imem_ready && !stall) begin
          ir_nxt_s    = imem_rdata;
          pc4_nxt_s   = pc_plus4_s;
          valid_nxt_s = 1'b1;
          pc_nxt_s    = pc_target_s;
        end else if (imem_ready) begin
          // Word arrived while decode is stalled: park it until the stall drops.
          buf_nxt_s   = imem_rdata;
          state_nxt_s = ST_HOLD;
        end else if (!stall) begin
          ir_nxt_s    = 32'h0000_0000;
          valid_nxt_s = 1'b0;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (flush) begin
          pc_nxt_s    = pc_target_s;
          ir_nxt_s    = 32'h0000_0000;
          valid_nxt_s = 1'b0;
          state_nxt_s = ST_FETCH;
        end else if (!stall) begin
          ir_nxt_s    = buf_r;
          pc4_nxt_s   = pc_plus4_s;
          valid_nxt_s = 1'b1;
          pc_nxt_s    = pc_target_s;
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_FETCH;
      end
    endcase
  end

  // Memory wait counter: every FETCH cycle without ready, flush or stall alike.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if ((state_r == ST_FETCH) && !imem_ready) begin
      cnt_nxt_s = sat_inc(cnt_r);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // State and pipeline registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_FETCH;
      pc_r    <= RESET_PC;
      ir_r    <= 32'h0000_0000;
      pc4_r   <= 32'h0000_0000;
      valid_r <= 1'b0;
      buf_r   <= 32'h0000_0000;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      ir_r    <= ir_nxt_s;
      pc4_r   <= pc4_nxt_s;
      valid_r <= valid_nxt_s;
      buf_r   <= buf_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed vector table, hand sequences for HOLD/reset and
// counter saturation, then randomized traffic against a behavioural model.
module tb_pc_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] next_pc;
  logic        stall;
  logic        flush;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  logic        a_req,   b_req;
  logic [31:0] a_addr,  b_addr;
  logic [31:0] a_pc,    b_pc;
  logic [31:0] a_ir,    b_ir;
  logic [31:0] a_pc4,   b_pc4;
  logic        a_valid, b_valid;
  logic [15:0] a_cnt;
  logic [3:0]  b_cnt;

  int total = 0;
  int bad   = 0;

  pc_fetch #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .next_pc(next_pc), .stall(stall), .flush(flush),
    .imem_req(a_req), .imem_addr(a_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .pc(a_pc), .ifid_ir(a_ir), .ifid_pc4(a_pc4), .ifid_valid(a_valid),
    .fetch_wait_cnt(a_cnt)
  );

  pc_fetch #(.RESET_PC(32'h0000_0000), .CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .next_pc(next_pc), .stall(stall), .flush(flush),
    .imem_req(b_req), .imem_addr(b_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .pc(b_pc), .ifid_ir(b_ir), .ifid_pc4(b_pc4), .ifid_valid(b_valid),
    .fetch_wait_cnt(b_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] npc;
    logic        st;
    logic        fl;
    logic        rdy;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_ir;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] npc, input logic st, input logic fl,
                       input logic rdy, input logic [31:0] rd);
    next_pc    = npc;
    stall      = st;
    flush      = fl;
    imem_ready = rdy;
    imem_rdata = rd;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    chk("rst_pc",    a_pc,    32'h0);
    chk("rst_ir",    a_ir,    32'h0);
    chk("rst_pc4",   a_pc4,   32'h0);
    chk("rst_valid", {31'h0, a_valid}, 32'h0);
    chk("rst_cnt",   {16'h0, a_cnt},   32'h0);
  endtask

  // Behavioural reference model
  logic [31:0] m_pc, m_ir, m_pc4, m_buf;
  logic        m_valid, m_holding;
  int          m_cnt;

  task automatic model_reset();
    m_pc = 32'h0; m_ir = 32'h0; m_pc4 = 32'h0; m_buf = 32'h0;
    m_valid = 1'b0; m_holding = 1'b0; m_cnt = 0;
  endtask

  task automatic model_step();
    logic [31:0] tgt;
    tgt = next_pc & 32'hFFFF_FFFC;
    if (!m_holding) begin
      if (!imem_ready) m_cnt = m_cnt + 1;
      if (flush) begin
        m_pc = tgt; m_ir = 32'h0; m_valid = 1'b0;
      end else if (imem_ready && !stall) begin
        m_ir = imem_rdata; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = tgt;
      end else if (imem_ready) begin
        m_buf = imem_rdata; m_holding = 1'b1;
      end else if (!stall) begin
        m_ir = 32'h0; m_valid = 1'b0;
      end
    end else begin
      if (flush) begin
        m_pc = tgt; m_ir = 32'h0; m_valid = 1'b0; m_holding = 1'b0;
      end else if (!stall) begin
        m_ir = m_buf; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = tgt; m_holding = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    //            npc           st    fl    rdy   rd            req   addr          pc            ir            pc4           vld   cnt
    tbl[0]  = '{32'h0000_0004, 1'b0, 1'b0, 1'b1, 32'h2008_0001, 1'b1, 32'h0000_0000, 32'h0000_0004, 32'h2008_0001, 32'h0000_0004, 1'b1, 16'd0};
    tbl[1]  = '{32'h0000_0008, 1'b0, 1'b0, 1'b1, 32'h2009_0002, 1'b1, 32'h0000_0004, 32'h0000_0008, 32'h2009_0002, 32'h0000_0008, 1'b1, 16'd0};
    tbl[2]  = '{32'h0000_0013, 1'b0, 1'b0, 1'b1, 32'h1111_1111, 1'b1, 32'h0000_0008, 32'h0000_0010, 32'h1111_1111, 32'h0000_000C, 1'b1, 16'd0};
    tbl[3]  = '{32'h0000_0099, 1'b0, 1'b0, 1'b0, 32'h5555_5555, 1'b1, 32'h0000_0010, 32'h0000_0010, 32'h0000_0000, 32'h0000_000C, 1'b0, 16'd1};
    tbl[4]  = '{32'h0000_0099, 1'b0, 1'b0, 1'b0, 32'h5555_5555, 1'b1, 32'h0000_0010, 32'h0000_0010, 32'h0000_0000, 32'h0000_000C, 1'b0, 16'd2};
    tbl[5]  = '{32'h0000_0099, 1'b0, 1'b0, 1'b0, 32'h5555_5555, 1'b1, 32'h0000_0010, 32'h0000_0010, 32'h0000_0000, 32'h0000_000C, 1'b0, 16'd3};
    tbl[6]  = '{32'h0000_0099, 1'b1, 1'b0, 1'b1, 32'hAC0A_0000, 1'b1, 32'h0000_0010, 32'h0000_0010, 32'h0000_0000, 32'h0000_000C, 1'b0, 16'd3};
    tbl[7]  = '{32'h0000_0099, 1'b1, 1'b0, 1'b1, 32'h7777_7777, 1'b0, 32'h0000_0010, 32'h0000_0010, 32'h0000_0000, 32'h0000_000C, 1'b0, 16'd3};
    tbl[8]  = '{32'h0000_0020, 1'b0, 1'b0, 1'b0, 32'h7777_7777, 1'b0, 32'h0000_0010, 32'h0000_0020, 32'hAC0A_0000, 32'h0000_0014, 1'b1, 16'd3};
    tbl[9]  = '{32'h0000_0403, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h0000_0020, 32'h0000_0400, 32'h0000_0000, 32'h0000_0014, 1'b0, 16'd3};
    tbl[10] = '{32'h0000_0404, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b1, 32'h0000_0400, 32'h0000_0404, 32'h1234_5678, 32'h0000_0404, 1'b1, 16'd3};
    tbl[11] = '{32'h0000_0008, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0404, 32'h0000_0008, 32'h0000_0000, 32'h0000_0404, 1'b0, 16'd4};
    tbl[12] = '{32'h0000_0030, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0008, 32'h0000_0008, 32'h0000_0000, 32'h0000_0404, 1'b0, 16'd5};
    tbl[13] = '{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b1, 32'h0000_0008, 32'hFFFF_FFFC, 32'hCAFE_F00D, 32'h0000_000C, 1'b1, 16'd5};
    tbl[14] = '{32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h0BAD_F00D, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0BAD_F00D, 32'h0000_0000, 1'b1, 16'd5};

    #2;
    chk("rst_req_low", {31'h0, a_req}, 32'h0);
    do_reset();

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].npc, tbl[i].st, tbl[i].fl, tbl[i].rdy, tbl[i].rd);
      #3;
      chk($sformatf("v%0d_req", i),  {31'h0, a_req}, {31'h0, tbl[i].e_req});
      chk($sformatf("v%0d_addr", i), a_addr, tbl[i].e_addr);
      tick();
      chk($sformatf("v%0d_pc", i),    a_pc,  tbl[i].e_pc);
      chk($sformatf("v%0d_ir", i),    a_ir,  tbl[i].e_ir);
      chk($sformatf("v%0d_pc4", i),   a_pc4, tbl[i].e_pc4);
      chk($sformatf("v%0d_valid", i), {31'h0, a_valid}, {31'h0, tbl[i].e_valid});
      chk($sformatf("v%0d_cnt", i),   {16'h0, a_cnt},   {16'h0, tbl[i].e_cnt});
    end

    // Enter HOLD, then reset asynchronously between edges
    drive(32'h0000_0040, 1'b0, 1'b0, 1'b1, 32'h0000_0001);
    tick();
    drive(32'h0000_0044, 1'b1, 1'b0, 1'b1, 32'h0000_0002);
    tick();
    chk("hold_req", {31'h0, a_req}, 32'h0);
    chk("hold_pc", a_pc, 32'h0000_0040);
    #2;
    reset = 1'b1;
    #1;
    chk("async_pc",    a_pc,  32'h0);
    chk("async_ir",    a_ir,  32'h0);
    chk("async_pc4",   a_pc4, 32'h0);
    chk("async_valid", {31'h0, a_valid}, 32'h0);
    chk("async_cnt",   {16'h0, a_cnt},   32'h0);
    chk("async_req",   {31'h0, a_req},   32'h0);
    tick();
    reset = 1'b0;
    drive(32'h0000_0004, 1'b0, 1'b0, 1'b1, 32'h0000_0ABC);
    #3;
    chk("post_rst_req",  {31'h0, a_req}, 32'h1);
    chk("post_rst_addr", a_addr, 32'h0);
    tick();
    chk("post_rst_ir", a_ir, 32'h0000_0ABC);

    // Counter saturation on the 4-bit instance
    do_reset();
    drive(32'h0000_0100, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 14) chk("sat_at15", {28'h0, b_cnt}, 32'hF);
    end
    chk("sat_4bit",  {28'h0, b_cnt}, 32'hF);
    chk("sat_16bit", {16'h0, a_cnt}, 32'd20);

    // Randomized traffic against the model
    do_reset();
    model_reset();
    for (int i = 0; i < 600; i++) begin
      drive($urandom, ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 9) < 6), $urandom);
      #3;
      chk("rnd_req",  {31'h0, a_req}, {31'h0, !m_holding});
      chk("rnd_addr", a_addr, m_pc);
      chk("rnd_req4", {31'h0, b_req}, {31'h0, !m_holding});
      chk("rnd_addr4", b_addr, m_pc);
      tick();
      model_step();
      chk("rnd_pc",    a_pc,  m_pc);
      chk("rnd_ir",    a_ir,  m_ir);
      chk("rnd_pc4",   a_pc4, m_pc4);
      chk("rnd_valid", {31'h0, a_valid}, {31'h0, m_valid});
      chk("rnd_cnt",   {16'h0, a_cnt}, (m_cnt > 65535) ? 32'd65535 : m_cnt);
      chk("rnd_pc_4",  b_pc,  m_pc);
      chk("rnd_ir_4",  b_ir,  m_ir);
      chk("rnd_pc4_4", b_pc4, m_pc4);
      chk("rnd_valid_4", {31'h0, b_valid}, {31'h0, m_valid});
      chk("rnd_cnt_4", {28'h0, b_cnt}, (m_cnt > 15) ? 32'd15 : m_cnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
